// File: rtl/frame_parser_pkg.sv
// Shared definitions for the ASCII frame parser: FSM encoding, error causes
// and the ASCII hex digit decoder.
package frame_parser_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        CMD  = 2'd1,
        LEN  = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CMD  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_DATA = 2'd3;

    // Returns {is_hex, nibble}; only '0'-'9' and uppercase 'A'-'F' are hex.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b1, 4'(c - 8'h37)};
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_parser_if.sv
// Byte-in / word-out bus of the frame parser. The parser uses the slave
// modport; whoever feeds bytes and drains words uses master.
interface frame_parser_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [3:0]        cmd;
    logic              cmd_valid;
    logic [15:0]       len;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              frame_done;
    logic              err;
    logic [1:0]        err_code;
    logic              busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, cmd, cmd_valid, len, out_valid, out_data,
               frame_done, err, err_code, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, cmd, cmd_valid, len, out_valid, out_data,
               frame_done, err, err_code, busy
    );
endinterface

// File: rtl/frame_fifo.sv
// Generic synchronous FIFO. A push while full is taken only if a pop
// happens in the same cycle, since the pop frees the slot.
module frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/frame_parser.sv
// ASCII frame parser: hunts for a 4-byte sync word, then decodes a hex
// command nibble, a hex length field and that many hex-encoded data words,
// which are queued in an output FIFO.
module frame_parser
    import frame_parser_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          LEN_DIGITS = 4,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] SYNC       = 32'h4C454146
) (
    input  logic         clk,
    input  logic         rst,
    frame_parser_if.slave bus
);
    localparam logic [2:0] LEN_LAST = 3'(LEN_DIGITS - 1);
    localparam logic [4:0] NIB_LAST = 5'(DATA_W / 4 - 1);

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       sync_sh;
    logic [15:0]       len_acc;
    logic [15:0]       len_reg;
    logic [15:0]       word_cnt;
    logic [2:0]        digit_cnt;
    logic [4:0]        nib_cnt;
    logic [DATA_W-1:0] word_acc;
    logic [3:0]        cmd_reg;
    logic              cmd_valid_reg;
    logic              err_reg;
    logic [1:0]        err_code_reg;

    logic              in_ready_int;
    logic              accept;
    logic              is_hex;
    logic [3:0]        nib;
    logic [31:0]       sync_next;
    logic [15:0]       len_next;
    logic [DATA_W-1:0] word_next;
    logic              len_last;
    logic              nib_last;
    logic              word_last;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              frame_done;
    logic [1:0]        err_cause;

    assign {is_hex, nib} = hex_decode(bus.in_data);
    assign in_ready_int  = (state == DATA) ? !fifo_full : 1'b1;
    assign accept        = bus.in_valid && in_ready_int;
    assign sync_next     = (sync_sh << 8) | {24'd0, bus.in_data};
    assign len_next      = (len_acc << 4) | {12'd0, nib};
    assign word_next     = (word_acc << 4) | DATA_W'(nib);
    assign len_last      = (digit_cnt == LEN_LAST);
    assign nib_last      = (nib_cnt == NIB_LAST);
    assign word_last     = ((word_cnt + 16'd1) == len_reg);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the same-cycle push, frame_done and error cause.
    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        frame_done = 1'b0;
        err_cause  = ERR_NONE;
        case (state)
            HUNT: begin
                if (accept && sync_next == SYNC) begin
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (accept) begin
                    if (is_hex) begin
                        state_nxt = LEN;
                    end else begin
                        err_cause = ERR_CMD;
                        state_nxt = HUNT;
                    end
                end
            end
            LEN: begin
                if (accept) begin
                    if (!is_hex) begin
                        err_cause = ERR_LEN;
                        state_nxt = HUNT;
                    end else if (len_last) begin
                        if (len_next == 16'd0) begin
                            frame_done = 1'b1;
                            state_nxt  = HUNT;
                        end else begin
                            state_nxt = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    if (!is_hex) begin
                        err_cause = ERR_DATA;
                        state_nxt = HUNT;
                    end else if (nib_last) begin
                        push = 1'b1;
                        if (word_last) begin
                            frame_done = 1'b1;
                            state_nxt  = HUNT;
                        end
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Datapath: sync shifter, command/length/word accumulators, status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_sh       <= '0;
            len_acc       <= '0;
            len_reg       <= '0;
            word_cnt      <= '0;
            digit_cnt     <= '0;
            nib_cnt       <= '0;
            word_acc      <= '0;
            cmd_reg       <= '0;
            cmd_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            cmd_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            if (err_cause != ERR_NONE) begin
                err_reg      <= 1'b1;
                err_code_reg <= err_cause;
            end
            if (state == HUNT && accept) begin
                sync_sh <= sync_next;
            end else if (state != HUNT && state_nxt == HUNT) begin
                sync_sh <= '0;
            end
            case (state)
                CMD: begin
                    if (accept && is_hex) begin
                        cmd_reg       <= nib;
                        cmd_valid_reg <= 1'b1;
                        len_acc       <= '0;
                        digit_cnt     <= '0;
                    end
                end
                LEN: begin
                    if (accept && is_hex) begin
                        len_acc   <= len_next;
                        digit_cnt <= digit_cnt + 3'd1;
                        if (len_last) begin
                            len_reg  <= len_next;
                            word_cnt <= '0;
                            nib_cnt  <= '0;
                            word_acc <= '0;
                        end
                    end
                end
                DATA: begin
                    if (accept && is_hex) begin
                        if (nib_last) begin
                            nib_cnt  <= '0;
                            word_acc <= '0;
                            word_cnt <= word_cnt + 16'd1;
                        end else begin
                            word_acc <= word_next;
                            nib_cnt  <= nib_cnt + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    frame_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (word_next),
        .pop       (bus.out_ready),
        .pop_data  (bus.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.in_ready   = in_ready_int;
    assign bus.cmd        = cmd_reg;
    assign bus.cmd_valid  = cmd_valid_reg;
    assign bus.len        = len_reg;
    assign bus.out_valid  = !fifo_empty;
    assign bus.frame_done = frame_done;
    assign bus.err        = err_reg;
    assign bus.err_code   = err_code_reg;
    assign bus.busy       = (state != HUNT);
endmodule

// File: tb/tb_frame_parser.sv
// Directed bench for frame_parser: a table of whole frames on a 32-bit
// instance, hand sequences for backpressure and mid-frame reset, and an
// 8-bit/2-digit instance for the narrow configuration.
module tb_frame_parser;

    logic clk;
    logic rst;

    frame_parser_if #(.DATA_W(32)) bus32 ();
    frame_parser_if #(.DATA_W(8))  bus8 ();

    frame_parser #(
        .DATA_W(32), .LEN_DIGITS(4), .FIFO_DEPTH(4), .SYNC(32'h4C454146)
    ) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    frame_parser #(
        .DATA_W(8), .LEN_DIGITS(2), .FIFO_DEPTH(4), .SYNC(32'h4C454146)
    ) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    typedef struct {
        string       text;
        logic [3:0]  cmd;
        logic [15:0] len;
        int          cv;
        int          fd;
        int          er;
        logic [1:0]  code;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    int total = 0;
    int bad   = 0;

    int          cv32 = 0, fd32 = 0, er32 = 0;
    int          cv8  = 0, fd8  = 0, er8  = 0;
    logic [31:0] q32[$];
    logic [7:0]  q8[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor on the falling edge, away from the active clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus32.cmd_valid)  cv32++;
            if (bus32.frame_done) fd32++;
            if (bus32.err)        er32++;
            if (bus32.out_valid && bus32.out_ready) q32.push_back(bus32.out_data);
            if (bus8.cmd_valid)   cv8++;
            if (bus8.frame_done)  fd8++;
            if (bus8.err)         er8++;
            if (bus8.out_valid && bus8.out_ready) q8.push_back(bus8.out_data);
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one byte and hold it until the selected DUT accepts it.
    task automatic send_byte(input bit sel, input logic [7:0] b);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        if (sel) begin bus8.in_valid = 1'b1;  bus8.in_data = b; end
        else     begin bus32.in_valid = 1'b1; bus32.in_data = b; end
        while (!ok && n < 200) begin
            @(negedge clk);
            if (sel ? bus8.in_ready : bus32.in_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL accept timeout: byte 0x%0h never accepted", b);
        end
        @(posedge clk);
        #1;
        if (sel) bus8.in_valid = 1'b0;
        else     bus32.in_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input bit sel, input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(sel, s[i]);
        end
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    vec_t vecs[9];
    int   cv_b, fd_b, er_b, q_b;

    initial begin
        vecs[0] = '{"LEAF30002DEADBEEF01234567", 4'h3, 16'd2, 1, 1, 0, 2'd0, 2, 32'hDEADBEEF, 32'h01234567};
        vecs[1] = '{"XLLEAF50000",               4'h5, 16'd0, 1, 1, 0, 2'd0, 0, 32'h0,        32'h0};
        vecs[2] = '{"LEAF2000112G4",             4'h2, 16'd1, 1, 0, 1, 2'd3, 0, 32'h0,        32'h0};
        vecs[3] = '{"LEAFC0001CAFEF00D",         4'hC, 16'd1, 1, 1, 0, 2'd0, 1, 32'hCAFEF00D, 32'h0};
        vecs[4] = '{"LEAFZ",                     4'hC, 16'd1, 0, 0, 1, 2'd1, 0, 32'h0,        32'h0};
        vecs[5] = '{"LEAF70a",                   4'h7, 16'd1, 1, 0, 1, 2'd2, 0, 32'h0,        32'h0};
        vecs[6] = '{"LEAFF000109AF0F9A",         4'hF, 16'd1, 1, 1, 0, 2'd0, 1, 32'h09AF0F9A, 32'h0};
        vecs[7] = '{"LEAF10001/",                4'h1, 16'd1, 1, 0, 1, 2'd3, 0, 32'h0,        32'h0};
        vecs[8] = '{"LEAF:",                     4'h1, 16'd1, 0, 0, 1, 2'd1, 0, 32'h0,        32'h0};

        rst = 1'b1;
        bus32.in_valid = 1'b0; bus32.in_data = 8'h00; bus32.out_ready = 1'b1;
        bus8.in_valid  = 1'b0; bus8.in_data  = 8'h00; bus8.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("reset in_ready",  bus32.in_ready, 1);
        check_output("reset busy",      bus32.busy, 0);
        check_output("reset out_valid", bus32.out_valid, 0);
        check_output("reset cmd",       bus32.cmd, 0);
        check_output("reset len",       bus32.len, 0);
        check_output("reset err_code",  bus32.err_code, 0);
        check_output("reset pulses",    {bus32.cmd_valid, bus32.frame_done, bus32.err}, 0);
        check_output("reset in_ready8", bus8.in_ready, 1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 9; v++) begin
            cv_b = cv32; fd_b = fd32; er_b = er32; q_b = q32.size();
            apply_stimulus(1'b0, vecs[v].text);
            settle(6);
            check_output($sformatf("v%0d cmd", v),       bus32.cmd, vecs[v].cmd);
            check_output($sformatf("v%0d len", v),       bus32.len, vecs[v].len);
            check_output($sformatf("v%0d cmd_valid", v), cv32 - cv_b, vecs[v].cv);
            check_output($sformatf("v%0d frame_done", v), fd32 - fd_b, vecs[v].fd);
            check_output($sformatf("v%0d err", v),       er32 - er_b, vecs[v].er);
            if (vecs[v].er != 0)
                check_output($sformatf("v%0d err_code", v), bus32.err_code, vecs[v].code);
            check_output($sformatf("v%0d words", v),     q32.size() - q_b, vecs[v].nw);
            if (vecs[v].nw > 0 && q32.size() > q_b)
                check_output($sformatf("v%0d word0", v), q32[q_b], vecs[v].w0);
            if (vecs[v].nw > 1 && q32.size() > q_b + 1)
                check_output($sformatf("v%0d word1", v), q32[q_b + 1], vecs[v].w1);
            check_output($sformatf("v%0d busy", v),      bus32.busy, 0);
            @(posedge clk);
            #1;
        end

        // Backpressure: six words into a four-deep FIFO with the sink stalled.
        fd_b = fd32; q_b = q32.size();
        bus32.out_ready = 1'b0;
        apply_stimulus(1'b0, "LEAF10006");
        for (int k = 1; k <= 4; k++) apply_stimulus(1'b0, $sformatf("%08X", k));
        @(negedge clk);
        check_output("bp in_ready full", bus32.in_ready, 0);
        check_output("bp out_valid",     bus32.out_valid, 1);
        check_output("bp head",          bus32.out_data, 32'h1);
        repeat (3) @(negedge clk);
        check_output("bp head hold",     bus32.out_data, 32'h1);
        check_output("bp still full",    bus32.in_ready, 0);
        @(posedge clk);
        #1;
        bus32.out_ready = 1'b1;
        for (int k = 5; k <= 6; k++) apply_stimulus(1'b0, $sformatf("%08X", k));
        settle(8);
        check_output("bp word count", q32.size() - q_b, 6);
        for (int k = 0; k < 6; k++) begin
            if (q32.size() > q_b + k)
                check_output($sformatf("bp word%0d", k), q32[q_b + k], k + 1);
        end
        check_output("bp frame_done", fd32 - fd_b, 1);
        check_output("bp busy",       bus32.busy, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of the second of three words.
        bus32.out_ready = 1'b0;
        apply_stimulus(1'b0, "LEAF40003AAAAAAAABBB");
        @(negedge clk);
        check_output("mid out_valid", bus32.out_valid, 1);
        check_output("mid busy",      bus32.busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst out_valid", bus32.out_valid, 0);
        check_output("rst busy",      bus32.busy, 0);
        check_output("rst len",       bus32.len, 0);
        check_output("rst cmd",       bus32.cmd, 0);
        check_output("rst in_ready",  bus32.in_ready, 1);
        bus32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        cv_b = cv32; fd_b = fd32; q_b = q32.size();
        apply_stimulus(1'b0, "LEAF60000");
        settle(4);
        check_output("post cmd",        bus32.cmd, 4'h6);
        check_output("post cmd_valid",  cv32 - cv_b, 1);
        check_output("post frame_done", fd32 - fd_b, 1);
        check_output("post words",      q32.size() - q_b, 0);
        @(posedge clk);
        #1;

        // Narrow configuration: byte words, two length digits.
        fd_b = fd8; er_b = er8; q_b = q8.size();
        apply_stimulus(1'b1, "LEAFA031F2E3D");
        settle(6);
        check_output("n8 cmd",        bus8.cmd, 4'hA);
        check_output("n8 len",        bus8.len, 16'd3);
        check_output("n8 frame_done", fd8 - fd_b, 1);
        check_output("n8 err",        er8 - er_b, 0);
        check_output("n8 words",      q8.size() - q_b, 3);
        if (q8.size() > q_b)     check_output("n8 word0", q8[q_b],     8'h1F);
        if (q8.size() > q_b + 1) check_output("n8 word1", q8[q_b + 1], 8'h2E);
        if (q8.size() > q_b + 2) check_output("n8 word2", q8[q_b + 2], 8'h3D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
